// File: rtl/lcd_byte_sequencer_if.sv
// Request and frame-writer signals of the LCD byte sequencer.
// slave  : the sequencer side (takes LCD byte requests, drives frames to the writer)
// master : the requester / writer side (drives requests and done, observes frames)
interface lcd_byte_sequencer_if;
    logic       start;
    logic [7:0] byte_in;
    logic       rs;
    logic       backlight;
    logic       busy;
    logic       cmd_done;
    logic       en_write;
    logic       start_frame;
    logic       stop_frame;
    logic [7:0] data_frame;
    logic       done;

    modport slave (
        input  start, byte_in, rs, backlight, done,
        output busy, cmd_done, en_write, start_frame, stop_frame, data_frame
    );

    modport master (
        output start, byte_in, rs, backlight, done,
        input  busy, cmd_done, en_write, start_frame, stop_frame, data_frame
    );
endinterface

// File: rtl/lcd_byte_sequencer.sv
// Splits one HD44780 command/data byte into five PCF8574 I2C frames
// (address+W, high nibble EN pulse, low nibble EN pulse), hands them to the
// frame writer over en_write/done, then waits the execution holdoff.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for start; byte/rs/backlight latched on accept
//  SEND    | en_write high, frame[idx] presented until writer reports done
//  RELEASE | en_write low, waiting for done to drop before next frame
//  HOLD    | holdoff down-counter running after the last frame
module lcd_byte_sequencer #(
    parameter logic [6:0]  I2C_ADDR  = 7'h27,
    parameter int unsigned DELAY_CYC = 50,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk_1MHz,
    input  logic                 rst,
    lcd_byte_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'd4;

    // Holdoff counts down from DELAY_CYC-1 to zero; the terminal count ends the command.
    localparam logic [CNT_W-1:0] HOLD_LOAD = (DELAY_CYC == 0) ? '0 : CNT_W'(DELAY_CYC - 1);

    logic [1:0]       state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             bl_q;
    logic             busy_q;
    logic             cmd_done_q;
    logic             en_write_q;
    logic             start_frame_q;
    logic             stop_frame_q;
    logic [7:0]       data_frame_q;
    logic [2:0]       idx_nxt;

    // Frame word {start_frame, stop_frame, data} for frame index i.
    // Nibble frames map onto the expander as {nib, BL, EN, RW=0, RS}.
    function automatic logic [9:0] frame_word(input logic [2:0] i, input logic [7:0] b,
                                              input logic r, input logic l);
        logic [3:0] nib;
        logic       en;
        nib = (i < 3'd3) ? b[7:4] : b[3:0];
        en  = (i == 3'd1) || (i == 3'd3);
        if (i == 3'd0) begin
            frame_word = {1'b1, 1'b0, I2C_ADDR, 1'b0};
        end else begin
            frame_word = {1'b0, (i == LAST_IDX), nib, l, en, 1'b0, r};
        end
    endfunction

    assign idx_nxt = idx + 3'd1;

    // Sequencer FSM; frame outputs are only reloaded when a new frame is launched,
    // so they keep their last value while en_write is low.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 3'd0;
            cnt           <= '0;
            byte_q        <= 8'h00;
            rs_q          <= 1'b0;
            bl_q          <= 1'b0;
            busy_q        <= 1'b0;
            cmd_done_q    <= 1'b0;
            en_write_q    <= 1'b0;
            start_frame_q <= 1'b0;
            stop_frame_q  <= 1'b0;
            data_frame_q  <= 8'h00;
        end else begin
            cmd_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        byte_q     <= bus.byte_in;
                        rs_q       <= bus.rs;
                        bl_q       <= bus.backlight;
                        idx        <= 3'd0;
                        busy_q     <= 1'b1;
                        en_write_q <= 1'b1;
                        {start_frame_q, stop_frame_q, data_frame_q} <=
                            frame_word(3'd0, bus.byte_in, bus.rs, bus.backlight);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // A done that is already high on entry still completes the frame.
                    if (bus.done) begin
                        en_write_q <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Waiting for done low keeps a stuck-high done from skipping frames.
                    if (!bus.done) begin
                        if (idx != LAST_IDX) begin
                            idx        <= idx_nxt;
                            en_write_q <= 1'b1;
                            {start_frame_q, stop_frame_q, data_frame_q} <=
                                frame_word(idx_nxt, byte_q, rs_q, bl_q);
                            state      <= SEND;
                        end else if (DELAY_CYC == 0) begin
                            busy_q     <= 1'b0;
                            cmd_done_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt   <= HOLD_LOAD;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        busy_q     <= 1'b0;
                        cmd_done_q <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.cmd_done    = cmd_done_q;
    assign bus.en_write    = en_write_q;
    assign bus.start_frame = start_frame_q;
    assign bus.stop_frame  = stop_frame_q;
    assign bus.data_frame  = data_frame_q;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Scoreboard bench for lcd_byte_sequencer: lane 0 uses a 50-cycle holdoff,
// lane 1 has no holdoff. A frame-writer model answers en_write on each lane.
module tb_lcd_byte_sequencer;
    localparam int NDUT    = 2;
    localparam int INT_MAX = 2147483647;
    localparam int DLY_A   = 50;
    localparam int DLY_B   = 0;
    localparam logic [6:0] ADDR = 7'h27;

    typedef struct packed {
        logic       s;
        logic       p;
        logic [7:0] d;
    } frame_t;

    logic clk_1MHz = 1'b0;
    logic rst      = 1'b1;
    int   cyc      = 0;

    logic       start_s [NDUT];
    logic [7:0] byte_s  [NDUT];
    logic       rs_s    [NDUT];
    logic       bl_s    [NDUT];
    logic       done_s  [NDUT];
    logic       en_o    [NDUT];
    logic       sf_o    [NDUT];
    logic       pf_o    [NDUT];
    logic [7:0] df_o    [NDUT];
    logic       busy_o  [NDUT];
    logic       cd_o    [NDUT];

    int wr_lat  [NDUT];
    int wr_hold [NDUT];
    int free_at [NDUT];   // first cycle in which the lane is idle again
    int acc_cyc [NDUT];   // cycle in which the last accepted start was driven
    bit cur_last[NDUT];   // frame currently in flight is the last of its command

    frame_t exp_q  [NDUT][$];
    int     done_q [NDUT][$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_1MHz = ~clk_1MHz;

    initial forever begin
        @(posedge clk_1MHz);
        cyc = cyc + 1;
    end

    function automatic int dly(input int g);
        return (g == 0) ? DLY_A : DLY_B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : lane
        lcd_byte_sequencer_if bus ();

        assign bus.start     = start_s[g];
        assign bus.byte_in   = byte_s[g];
        assign bus.rs        = rs_s[g];
        assign bus.backlight = bl_s[g];
        assign bus.done      = done_s[g];
        assign en_o[g]       = bus.en_write;
        assign sf_o[g]       = bus.start_frame;
        assign pf_o[g]       = bus.stop_frame;
        assign df_o[g]       = bus.data_frame;
        assign busy_o[g]     = bus.busy;
        assign cd_o[g]       = bus.cmd_done;

        lcd_byte_sequencer #(
            .I2C_ADDR (ADDR),
            .DELAY_CYC((g == 0) ? DLY_A : DLY_B),
            .CNT_W    (16)
        ) dut (
            .clk_1MHz(clk_1MHz),
            .rst     (rst),
            .bus     (bus)
        );

        // Frame writer model: done rises wr_lat cycles into en_write, stays wr_hold cycles.
        int w_cnt;
        initial begin
            w_cnt     = 0;
            done_s[g] = 1'b0;
            forever begin
                @(posedge clk_1MHz);
                #2;
                if (rst) begin
                    done_s[g] = 1'b0;
                    w_cnt     = 0;
                end else if (!done_s[g]) begin
                    if (en_o[g]) begin
                        if (w_cnt >= wr_lat[g] - 1) begin
                            done_s[g] = 1'b1;
                            w_cnt     = 0;
                        end else begin
                            w_cnt++;
                        end
                    end else begin
                        w_cnt = 0;
                    end
                end else if (w_cnt >= wr_hold[g] - 1) begin
                    done_s[g] = 1'b0;
                    w_cnt     = 0;
                    if (cur_last[g]) begin
                        cur_last[g] = 1'b0;
                        free_at[g]  = cyc + 1 + dly(g);
                        done_q[g].push_back(free_at[g]);
                    end
                end else begin
                    w_cnt++;
                end
            end
        end

        // Monitor: pops an expected frame on every en_write rise and checks held outputs.
        logic   prev_en;
        logic   prev_done;
        logic   exp_busy;
        frame_t cur_f;
        initial begin
            prev_en   = 1'b0;
            prev_done = 1'b0;
            cur_f     = '0;
            forever begin
                @(negedge clk_1MHz);
                if (rst) begin
                    prev_en   = 1'b0;
                    prev_done = 1'b0;
                    cur_f     = '0;
                end else begin
                    if (en_o[g] && !prev_en) begin
                        if (exp_q[g].size() == 0) begin
                            chk("unexpected_frame", 32'd1, 32'd0);
                        end else begin
                            cur_f       = exp_q[g].pop_front();
                            cur_last[g] = cur_f.p;
                        end
                    end
                    chk("start_frame", {31'd0, sf_o[g]}, {31'd0, cur_f.s});
                    chk("stop_frame", {31'd0, pf_o[g]}, {31'd0, cur_f.p});
                    chk("data_frame", {24'd0, df_o[g]}, {24'd0, cur_f.d});
                    if (prev_done && done_s[g]) begin
                        chk("en_write_while_done", {31'd0, en_o[g]}, 32'd0);
                    end
                    exp_busy = (cyc > acc_cyc[g]) && (cyc < free_at[g]);
                    chk("busy", {31'd0, busy_o[g]}, {31'd0, exp_busy});
                    while (done_q[g].size() > 0 && cyc > done_q[g][0]) begin
                        chk("cmd_done_missing", done_q[g].pop_front(), 32'(cyc));
                    end
                    if (cd_o[g]) begin
                        if (done_q[g].size() == 0) begin
                            chk("cmd_done_unexpected", 32'd1, 32'd0);
                        end else begin
                            chk("cmd_done_cycle", 32'(cyc), done_q[g].pop_front());
                        end
                    end
                    prev_en   = en_o[g];
                    prev_done = done_s[g];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_1MHz);
        #2;
        for (int g = 0; g < NDUT; g++) start_s[g] = 1'b0;
    endtask

    // Drive one start; if the lane is idle the reference expects five frames.
    task automatic issue(input int g, input logic [7:0] b, input logic r, input logic l);
        logic [3:0] nib;
        start_s[g] = 1'b1;
        byte_s[g]  = b;
        rs_s[g]    = r;
        bl_s[g]    = l;
        if (cyc >= free_at[g]) begin
            free_at[g] = INT_MAX;
            acc_cyc[g] = cyc;
            exp_q[g].push_back('{s: 1'b1, p: 1'b0, d: {ADDR, 1'b0}});
            for (int k = 0; k < 2; k++) begin
                nib = (k == 0) ? b[7:4] : b[3:0];
                exp_q[g].push_back('{s: 1'b0, p: 1'b0, d: {nib, l, 1'b1, 1'b0, r}});
                exp_q[g].push_back('{s: 1'b0, p: (k == 1), d: {nib, l, 1'b0, 1'b0, r}});
            end
        end
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (!(free_at[g] != INT_MAX && cyc > free_at[g]) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_frames_left(input int g, input int left, input int budget);
        int n = 0;
        while (exp_q[g].size() > left && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("frame_wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            chk({tag, "_en_write"}, {31'd0, en_o[g]}, 32'd0);
            chk({tag, "_frame_bits"}, {22'd0, sf_o[g], pf_o[g], df_o[g]}, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy_o[g]}, 32'd0);
            chk({tag, "_cmd_done"}, {31'd0, cd_o[g]}, 32'd0);
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < NDUT; g++) begin
            start_s[g]  = 1'b0;
            byte_s[g]   = 8'h00;
            rs_s[g]     = 1'b0;
            bl_s[g]     = 1'b0;
            wr_lat[g]   = 3;
            wr_hold[g]  = 1;
            free_at[g]  = 0;
            acc_cyc[g]  = -1;
            cur_last[g] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk_1MHz);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // Data 'A' with RS=1, backlight on, slow writer
        wr_lat[0] = 20;
        tick();
        issue(0, 8'h41, 1'b1, 1'b1);
        wait_idle(0, 1000);

        // Clear-display command, RS=0, backlight off
        wr_lat[0] = 3;
        tick();
        issue(0, 8'h01, 1'b0, 1'b0);
        wait_idle(0, 1000);

        // Second start during frame 2 is ignored, the one after cmd_done is taken
        wr_lat[0] = 4;
        tick();
        issue(0, 8'hA5, 1'b1, 1'b0);
        wait_frames_left(0, 2, 500);
        issue(0, 8'h3C, 1'b0, 1'b1);
        wait_idle(0, 1000);
        tick();
        issue(0, 8'h3C, 1'b0, 1'b1);
        wait_idle(0, 1000);

        // Writer holds done high for 10 cycles per frame
        wr_lat[0]  = 2;
        wr_hold[0] = 10;
        tick();
        issue(0, 8'h7E, 1'b1, 1'b1);
        wait_idle(0, 1000);
        wr_hold[0] = 1;

        // Reset in the middle of frame 3, then a fresh command from frame 0
        tick();
        issue(0, 8'hC3, 1'b0, 1'b1);
        wait_frames_left(0, 1, 500);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        for (int g = 0; g < NDUT; g++) begin
            exp_q[g].delete();
            done_q[g].delete();
            free_at[g]  = 0;
            acc_cyc[g]  = cyc;
            cur_last[g] = 1'b0;
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        issue(0, 8'h41, 1'b1, 1'b1);
        wait_idle(0, 1000);

        // No-holdoff lane: back-to-back start in the cmd_done cycle
        wr_lat[1] = 1;
        tick();
        issue(1, 8'h01, 1'b0, 1'b0);
        n = 0;
        while ((free_at[1] == INT_MAX || cyc < free_at[1]) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("b2b_timeout", 32'd1, 32'd0);
        else issue(1, 8'h0F, 1'b1, 1'b1);
        wait_idle(1, 500);

        // Random traffic: random starts (many while busy), inputs changing after accept
        for (int t = 0; t < 4000; t++) begin
            tick();
            if (t % 250 == 0) begin
                for (int g = 0; g < NDUT; g++) begin
                    wr_lat[g]  = $urandom_range(1, 6);
                    wr_hold[g] = $urandom_range(1, 4);
                end
            end
            for (int g = 0; g < NDUT; g++) begin
                byte_s[g] = 8'($urandom);
                rs_s[g]   = 1'($urandom_range(0, 1));
                bl_s[g]   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) begin
                    issue(g, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
        end
        tick();
        wait_idle(0, 2000);
        wait_idle(1, 2000);
        repeat (2) tick();
        for (int g = 0; g < NDUT; g++) begin
            chk("frames_left", 32'(exp_q[g].size()), 32'd0);
            chk("cmd_done_left", 32'(done_q[g].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
